// File: rtl/sipo_pkg.sv
// Shared constants for the serial-in / parallel-out collector.
package sipo_pkg;

  // Default number of serial bits per parallel word.
  localparam int WIDTH_DEFAULT = 8;

  // Single-bit state encoding: collecting bits vs. word waiting for consumer.
  localparam logic ST_FILL = 1'b0;
  localparam logic ST_HOLD = 1'b1;

endpackage

// File: rtl/sipo_collector_dffe_r.sv
// Single-bit D flip-flop with clock enable and synchronous active-high reset.
module dffe_r (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  // Reset wins over enable; otherwise load d when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sipo_collector.sv
// Serial-in, parallel-out word collector with a one-word holding register,
// consumer handshake and sticky overflow flag.
// Build option: MSB_FIRST_EN -- when defined the first received bit lands in
// pout[WIDTH-1] (shift left); otherwise it lands in pout[0] (shift right).
module sipo_collector
  import sipo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic             state;
  logic             state_d;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic             cnt_en;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shifted;
  logic             sr_en;
  logic             pout_en;
  logic             valid_d;
  logic             ovf_en;

  // Insert one serial bit into the shift register in the selected bit order.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic b);
`ifdef MSB_FIRST_EN
    return {v[WIDTH-2:0], b};
`else
    return {b, v[WIDTH-1:1]};
`endif
  endfunction

  // State register: FILL/HOLD bit plus the registered valid flag.
  dffe_r u_state (.clk(clk), .rst(rst), .en(1'b1), .d(state_d), .q(state));
  dffe_r u_valid (.clk(clk), .rst(rst), .en(1'b1), .d(valid_d), .q(pout_valid));

  // Next-state: a completed word moves to HOLD, a consumer handshake returns to FILL.
  always_comb begin
    state_d = state;
    if (state == ST_FILL) begin
      if (sin_en && (cnt == CNT_LAST)) begin
        state_d = ST_HOLD;
      end
    end else begin
      if (pout_ready) begin
        state_d = ST_FILL;
      end
    end
    valid_d = (state_d == ST_HOLD);
  end

  // Datapath controls: shift, count, word capture and overflow detection.
  always_comb begin
    shifted = shift_in(sr, sin);
    sr_en   = 1'b0;
    cnt_en  = 1'b0;
    cnt_d   = cnt;
    pout_en = 1'b0;
    ovf_en  = 1'b0;
    if (state == ST_FILL) begin
      if (sin_en) begin
        sr_en  = 1'b1;
        cnt_en = 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          pout_en = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
    end else begin
      if (sin_en) begin
        if (pout_ready) begin
          // Word is released this edge, so the bit starts the next word.
          sr_en  = 1'b1;
          cnt_en = 1'b1;
          cnt_d  = CNT_ONE;
        end else begin
          // No room: the bit is lost and everything else holds.
          ovf_en = 1'b1;
        end
      end
    end
  end

  // Sticky overflow: only reset clears it.
  dffe_r u_ovf (.clk(clk), .rst(rst), .en(ovf_en), .d(1'b1), .q(overflow));

  // Per-bit storage for the shift register, output word and bit counter.
  for (genvar i = 0; i < WIDTH; i++) begin : g_data
    dffe_r u_sr   (.clk(clk), .rst(rst), .en(sr_en),   .d(shifted[i]), .q(sr[i]));
    dffe_r u_pout (.clk(clk), .rst(rst), .en(pout_en), .d(shifted[i]), .q(pout[i]));
  end

  for (genvar i = 0; i < CW; i++) begin : g_cnt
    dffe_r u_cnt (.clk(clk), .rst(rst), .en(cnt_en), .d(cnt_d[i]), .q(cnt[i]));
  end

endmodule

// File: tb/tb_sipo_collector.sv
// Self-checking bench for sipo_collector (WIDTH=8) with a word-level model.
module tb_sipo_collector;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         sin;
  logic         sin_en;
  logic [W-1:0] pout;
  logic         pout_valid;
  logic         pout_ready;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: bits received for the current word, pending word, flags.
  bit           m_bits[$];
  logic [W-1:0] m_pout;
  bit           m_valid;
  bit           m_ovf;

  sipo_collector #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .sin(sin),
    .sin_en(sin_en),
    .pout(pout),
    .pout_valid(pout_valid),
    .pout_ready(pout_ready),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] assemble(input bit b[$]);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < b.size(); i++) begin
`ifdef MSB_FIRST_EN
      w[W-1-i] = b[i];
`else
      w[i] = b[i];
`endif
    end
    return w;
  endfunction

  // Bit order on the wire that yields the given word in pout.
  function automatic bit wire_bit(input logic [W-1:0] word, input int idx);
`ifdef MSB_FIRST_EN
    return word[W-1-idx];
`else
    return word[idx];
`endif
  endfunction

  task automatic model_update(input bit r, input bit en, input bit s, input bit rdy);
    if (r) begin
      m_bits.delete();
      m_pout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else if (!m_valid) begin
      if (en) begin
        m_bits.push_back(s);
        if (m_bits.size() == W) begin
          m_pout  = assemble(m_bits);
          m_valid = 1'b1;
          m_bits.delete();
        end
      end
    end else begin
      if (rdy) begin
        m_valid = 1'b0;
        if (en) m_bits.push_back(s);
      end else if (en) begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input bit r, input bit en, input bit s, input bit rdy);
    rst        = r;
    sin_en     = en;
    sin        = s;
    pout_ready = rdy;
    @(posedge clk);
    model_update(r, en, s, rdy);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1);
    checks++;
    if (pout !== '0) begin errors++; $display("FAIL reset_pout got %h want 00", pout); end
    checks++;
    if (pout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pout_valid); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_basic();
    logic [W-1:0] pat;
    logic [W-1:0] want;
    pat = 8'b0100_1101;  // bits 1,0,1,1,0,0,1,0 in arrival order from index 0
`ifdef MSB_FIRST_EN
    want = 8'hB2;
`else
    want = 8'h4D;
`endif
    step(1, 0, 0, 0);
    for (int i = 0; i < W; i++) step(0, 1, pat[i], 0);
    checks++;
    if (pout !== want) begin errors++; $display("FAIL basic_pout got %h want %h", pout, want); end
    checks++;
    if (pout_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", pout_valid); end
    checks++;
    if (pout !== m_pout) begin errors++; $display("FAIL basic_model got %h want %h", pout, m_pout); end
    step(0, 0, 0, 1);
    checks++;
    if (pout_valid !== 1'b0) begin errors++; $display("FAIL basic_consume got %b want 0", pout_valid); end
    checks++;
    if (pout !== want) begin errors++; $display("FAIL basic_keep got %h want %h", pout, want); end
  endtask

  task automatic test_gaps();
    logic [W-1:0] pat;
    logic [W-1:0] want;
    bit           early_valid;
    pat = 8'b0100_1101;
`ifdef MSB_FIRST_EN
    want = 8'hB2;
`else
    want = 8'h4D;
`endif
    early_valid = 1'b0;
    step(1, 0, 0, 0);
    for (int i = 0; i < W; i++) begin
      step(0, 1, pat[i], 1);
      if (i < W - 1 && pout_valid !== 1'b0) early_valid = 1'b1;
      if (i == 1 || i == 4) begin
        for (int g = 0; g < 3; g++) begin
          step(0, 0, 1, 1);
          if (pout_valid !== 1'b0) early_valid = 1'b1;
        end
      end
    end
    checks++;
    if (early_valid) begin errors++; $display("FAIL gaps_early_valid got 1 want 0"); end
    checks++;
    if (pout !== want || pout_valid !== 1'b1) begin
      errors++; $display("FAIL gaps_pout got %h/%b want %h/1", pout, pout_valid, want);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] held;
    step(1, 0, 0, 0);
    for (int i = 0; i < W; i++) step(0, 1, 1'($urandom_range(0, 1)), 0);
    held = pout;
    checks++;
    if (held !== m_pout) begin errors++; $display("FAIL ovf_word got %h want %h", held, m_pout); end
    step(0, 1, 1, 0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    checks++;
    if (pout !== m_pout || pout_valid !== 1'b1) begin
      errors++; $display("FAIL ovf_hold got %h/%b want %h/1", pout, pout_valid, m_pout);
    end
    step(0, 0, 0, 1);
    checks++;
    if (pout_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_release got valid %b ovf %b want 0 1", pout_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] want;
`ifdef MSB_FIRST_EN
    want = 8'h80;
`else
    want = 8'h01;
`endif
    step(1, 0, 0, 0);
    for (int i = 0; i < W; i++) step(0, 1, 1'($urandom_range(0, 1)), 0);
    step(0, 1, 1, 1);
    checks++;
    if (pout_valid !== 1'b0) begin errors++; $display("FAIL b2b_release got %b want 0", pout_valid); end
    for (int i = 0; i < W - 2; i++) step(0, 1, 0, 0);
    checks++;
    if (pout_valid !== 1'b0) begin errors++; $display("FAIL b2b_early got %b want 0", pout_valid); end
    step(0, 1, 0, 0);
    checks++;
    if (pout !== want || pout_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_word got %h/%b want %h/1", pout, pout_valid, want);
    end
  endtask

  task automatic test_reset_midword();
    logic [W-1:0] word;
    word = 8'hA5;
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    checks++;
    if (pout_valid !== 1'b0 || pout !== '0) begin
      errors++; $display("FAIL midrst_clear got %h/%b want 00/0", pout, pout_valid);
    end
    for (int i = 0; i < W; i++) step(0, 1, wire_bit(word, i), 0);
    checks++;
    if (pout !== 8'hA5 || pout_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_word got %h/%b want a5/1", pout, pout_valid);
    end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b want 0", overflow); end
  endtask

  task automatic test_random();
    bit r, en, s, rdy;
    step(1, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) < 6);
      s   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) == 0);
      step(r, en, s, rdy);
      checks++;
      if (pout !== m_pout || pout_valid !== m_valid || overflow !== m_ovf) begin
        errors++;
        $display("FAIL random_cycle%0d got %h/%b/%b want %h/%b/%b", n,
                 pout, pout_valid, overflow, m_pout, m_valid, m_ovf);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    sin        = 1'b0;
    sin_en     = 1'b0;
    pout_ready = 1'b0;
    m_pout     = '0;
    m_valid    = 1'b0;
    m_ovf      = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_back_to_back();
    test_reset_midword();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_collector.md
SIPO_COLLECTOR -- requirements
Module: sipo_collector

Interface
REQ-001 Parameter WIDTH, default 8: the number of serial bits per parallel word; the legal range SHALL be 2..32.
REQ-002 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 sin  input  1  Serial data bit, sampled only when sin_en=1.
REQ-005 sin_en  input  1  Serial bit strobe; one bit is offered per cycle in which it is high.
REQ-006 pout  output  WIDTH  Assembled parallel word; it SHALL be registered.
REQ-007 pout_valid  output  1  High when pout holds a complete, unconsumed word; it SHALL be registered.
REQ-008 pout_ready  input  1  Consumer accepts pout in any cycle where pout_valid=1 and pout_ready=1.
REQ-009 overflow  output  1  Sticky flag, set when a serial bit is dropped; it SHALL be registered.

Function
REQ-010 The block SHALL have two states: FILL (collecting bits) and HOLD (a word is waiting for the consumer).
REQ-011 Internal state SHALL be a WIDTH-bit shift register sr and a bit counter cnt of $clog2(WIDTH) bits.
REQ-012 In FILL, when sin_en=1 the block SHALL shift sin into sr and increment cnt; when sin_en=0, sr and cnt SHALL hold.
REQ-013 In FILL, when sin_en=1 and cnt=WIDTH-1:
- pout SHALL load the completed word, including the current bit.
- pout_valid SHALL go to 1 at that same edge (latency: 0 cycles after the last bit's edge).
- cnt SHALL reset to 0 and the state SHALL move to HOLD.
REQ-014 In HOLD, pout and pout_valid SHALL hold until a cycle with pout_ready=1. At that edge, pout_valid SHALL go to 0 and the state SHALL return to FILL; pout SHALL keep its last value.
REQ-015 In HOLD, sin_en=1 together with pout_ready=1 SHALL accept the bit as bit 1 of the next word (sr shifted, cnt=1).
REQ-016 In HOLD, sin_en=1 with pout_ready=0 SHALL drop the bit and set overflow=1; sr, cnt and pout SHALL be unchanged.
REQ-017 overflow SHALL remain 1 until rst.
REQ-018 pout_ready while pout_valid=0 SHALL have no effect.
REQ-019 The bits of a word SHALL NOT be required to arrive on consecutive cycles; gaps of any length SHALL be legal.

Reset
REQ-020 When rst=1 at a rising edge, the block SHALL set state=FILL, cnt=0, sr=0, pout=0, pout_valid=0 and overflow=0.
REQ-021 rst SHALL take priority over sin_en and pout_ready in the same cycle.
REQ-022 Reset in mid-word SHALL discard the partial word, and reset in HOLD SHALL discard the pending word; neither SHALL emit any partial output.

Configuration
REQ-023 The macro MSB_FIRST_EN SHALL select bit order.
- Defined: the first received bit SHALL land in pout[WIDTH-1] (shift left, new bit entering at LSB).
- Undefined: the first received bit SHALL land in pout[0] (shift right, new bit entering at MSB).
- All other behaviour SHALL be identical in both builds.

Structure
REQ-024 The shared package sipo_pkg SHALL hold the state encoding constants (ST_FILL=0, ST_HOLD=1) and the default WIDTH constant.
REQ-025 One sub-module, dffe_r, SHALL be used for each state bit: a D flip-flop with enable and synchronous active-high reset, instantiated per bit of sr, pout, cnt and the flags.
REQ-026 The next-state and shift logic SHALL be combinational in the top module; there SHALL be no latches.

Verification (WIDTH=8)
REQ-027 LSB-first build, sin=1,0,1,1,0,0,1,0 on 8 consecutive sin_en cycles -> after the 8th edge, pout=8'h4D and pout_valid=1. With MSB_FIRST_EN defined, the same stimulus -> pout=8'hB2.
REQ-028 Same 8 bits with 3 idle cycles inserted after bits 2 and 5 -> same pout value; pout_valid SHALL stay 0 until the 8th bit.
REQ-029 Word pending, pout_ready=0, one sin_en pulse -> overflow=1, pout unchanged, pout_valid=1; then pout_ready=1 -> pout_valid=0 on the next edge, overflow still 1.
REQ-030 Word pending, pout_ready=1 and sin_en=1 with sin=1 in the same cycle -> pout_valid=0, cnt=1; 7 further bits (all 0) -> pout=8'h01 in the LSB-first build.
REQ-031 5 bits sent, then rst pulsed for 1 cycle, then 8 bits of pattern 8'hA5 -> pout=8'hA5 exactly, with no residue from the discarded bits, and overflow=0.
